// File: rtl/sequencer_controller.sv
// Central scheduler for the 8-step sequencer: tempo/beat generation,
// STOPPED/RUNNING transport, edit cursor with toggle routing, and
// registered selection of the current beat's note for the tone generator.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | piano mode; beat, tick, note and toggle outputs held at 0
// ST_STOPPED | sequencer mode, transport paused; beat/tick held, edits live
// ST_RUNNING | sequencer mode, tick counter advancing the beat
module sequencer_controller #(
  parameter int STEPS         = 8,
  parameter int TICKS_DEFAULT = 2500,
  parameter int TICKS_MIN     = 500,
  parameter int TICKS_MAX     = 5000,
  parameter int TICKS_STEP    = 250
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sequencer_on_i,
  input  logic                 play_pause_i,
  input  logic                 cursor_next_i,
  input  logic                 cursor_prev_i,
  input  logic                 toggle_in_i,
  input  logic                 tempo_up_i,
  input  logic                 tempo_down_i,
  input  logic [4*STEPS-1:0]   step_notes_i,
  output logic [3:0]           beat_o,
  output logic                 beat_strobe_o,
  output logic [2:0]           cursor_o,
  output logic [STEPS-1:0]     step_toggle_o,
  output logic [3:0]           note_out_o,
  output logic                 running_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STOPPED = 2'd1,
    ST_RUNNING = 2'd2
  } state_t;

  localparam logic [15:0] P_DEFAULT = 16'(TICKS_DEFAULT);
  localparam logic [15:0] P_MIN     = 16'(TICKS_MIN);
  localparam logic [15:0] P_MAX     = 16'(TICKS_MAX);
  localparam logic [15:0] P_STEP    = 16'(TICKS_STEP);
  localparam logic [3:0]  BEAT_LAST = 4'(STEPS - 1);
  localparam logic [2:0]  CUR_LAST  = 3'(STEPS - 1);

  state_t             state_q, state_d;
  logic [15:0]        tick_q, tick_d;
  logic [15:0]        period_q, period_d;
  logic [3:0]         beat_q, beat_d;
  logic               strobe_q, strobe_d;
  logic [2:0]         cursor_q, cursor_d;
  logic [STEPS-1:0]   toggle_q, toggle_d;
  logic [3:0]         note_q, note_d;
  logic [3:0]         beat_note;
  logic               active;

  // Note of the step addressed by the current beat.
  always_comb begin
    beat_note = 4'd0;
    for (int k = 0; k < STEPS; k++) begin
      if (beat_q == 4'(k)) beat_note = step_notes_i[4*k +: 4];
    end
  end

  // Next-state logic for transport, tick counter, tempo, cursor, toggle and note.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    period_d = period_q;
    beat_d   = beat_q;
    strobe_d = 1'b0;
    cursor_d = cursor_q;
    toggle_d = '0;
    note_d   = note_q;

    // Edits are only honoured while in sequencer mode and not dropping out of it.
    active = (state_q != ST_IDLE) && sequencer_on_i;

    if (!sequencer_on_i) begin
      state_d = ST_IDLE;
      beat_d  = 4'd0;
      tick_d  = 16'd0;
      note_d  = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_STOPPED;
          beat_d  = 4'd0;
          tick_d  = 16'd0;
          note_d  = 4'd0;
        end
        ST_STOPPED: begin
          note_d = beat_note;
          if (play_pause_i) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          note_d = beat_note;
          if (play_pause_i) begin
            state_d = ST_STOPPED;
          end else if (tick_q >= (period_q - 16'd1)) begin
            // >= rather than == so a period shortened mid-beat wraps at once.
            tick_d   = 16'd0;
            beat_d   = (beat_q == BEAT_LAST) ? 4'd0 : beat_q + 4'd1;
            strobe_d = 1'b1;
          end else begin
            tick_d = tick_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Tempo adjusts in every state, saturating at the period limits.
    if (tempo_up_i && !tempo_down_i) begin
      period_d = (period_q >= P_MIN + P_STEP) ? period_q - P_STEP : P_MIN;
    end else if (tempo_down_i && !tempo_up_i) begin
      period_d = (period_q <= P_MAX - P_STEP) ? period_q + P_STEP : P_MAX;
    end

    // Toggle is routed from the pre-move cursor so a same-cycle move doesn't retarget it.
    if (active) begin
      if (toggle_in_i) toggle_d[cursor_q] = 1'b1;
      if (cursor_next_i && !cursor_prev_i) begin
        cursor_d = (cursor_q == CUR_LAST) ? 3'd0 : cursor_q + 3'd1;
      end else if (cursor_prev_i && !cursor_next_i) begin
        cursor_d = (cursor_q == 3'd0) ? CUR_LAST : cursor_q - 3'd1;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      tick_q   <= 16'd0;
      period_q <= P_DEFAULT;
      beat_q   <= 4'd0;
      strobe_q <= 1'b0;
      cursor_q <= 3'd0;
      toggle_q <= '0;
      note_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      period_q <= period_d;
      beat_q   <= beat_d;
      strobe_q <= strobe_d;
      cursor_q <= cursor_d;
      toggle_q <= toggle_d;
      note_q   <= note_d;
    end
  end

  assign beat_o        = beat_q;
  assign beat_strobe_o = strobe_q;
  assign cursor_o      = cursor_q;
  assign step_toggle_o = toggle_q;
  assign note_out_o    = note_q;
  assign running_o     = (state_q == ST_RUNNING);

endmodule

// File: tb/tb_sequencer_controller.sv
// Directed bench for sequencer_controller: transport, tempo limits,
// cursor/toggle routing, note select, pause/resume, mode drop and reset.
module tb_sequencer_controller;

  logic        clk = 1'b0;
  logic        rst, seq_on, play_pause, cur_next, cur_prev, toggle_in;
  logic        tempo_up, tempo_down;
  logic [31:0] step_notes;
  logic [3:0]  beat;
  logic        beat_strobe;
  logic [2:0]  cursor;
  logic [7:0]  step_toggle;
  logic [3:0]  note_out;
  logic        running;

  int checks = 0;
  int errors = 0;
  int n;
  logic quiet;

  always #5 clk = ~clk;

  sequencer_controller dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sequencer_on_i (seq_on),
    .play_pause_i   (play_pause),
    .cursor_next_i  (cur_next),
    .cursor_prev_i  (cur_prev),
    .toggle_in_i    (toggle_in),
    .tempo_up_i     (tempo_up),
    .tempo_down_i   (tempo_down),
    .step_notes_i   (step_notes),
    .beat_o         (beat),
    .beat_strobe_o  (beat_strobe),
    .cursor_o       (cursor),
    .step_toggle_o  (step_toggle),
    .note_out_o     (note_out),
    .running_o      (running)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Cycles until the next strobe is seen, or -1 if the limit expires.
  task automatic wait_strobe(input int limit, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (beat_strobe !== 1'b1 && cnt < limit);
    if (beat_strobe !== 1'b1) cnt = -1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; seq_on = 1'b0; play_pause = 1'b0; cur_next = 1'b0; cur_prev = 1'b0;
    toggle_in = 1'b0; tempo_up = 1'b0; tempo_down = 1'b0;
    step_notes = 32'h0000_5000;   // step 3 = 5, all others silent

    // Reset state
    cyc(2);
    chk("rst_beat", beat, 0);
    chk("rst_running", running, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_toggle", step_toggle, 0);
    chk("rst_note", note_out, 0);
    chk("rst_strobe", beat_strobe, 0);

    // IDLE -> STOPPED -> RUNNING
    rst = 1'b0; seq_on = 1'b1;
    cyc(1);
    chk("stopped_running", running, 0);
    play_pause = 1'b1; cyc(1); play_pause = 1'b0;
    chk("run_entry", running, 1);

    // First strobe 2500 cycles after RUNNING entry, lasting one cycle
    wait_strobe(3000, n);
    chk("strobe1_cycles", n, 2500);
    chk("strobe1_beat", beat, 1);
    cyc(1);
    chk("strobe1_width", beat_strobe, 0);
    wait_strobe(3000, n);
    chk("strobe2_cycles", n, 2499);
    chk("strobe2_beat", beat, 2);

    // Note select: beat 3 -> note 5 one cycle later, beat 4 -> silence one cycle later
    wait_strobe(3000, n);
    chk("strobe3_cycles", n, 2500);
    chk("beat3", beat, 3);
    chk("note_latency_b3", note_out, 0);
    cyc(1);
    chk("note_b3", note_out, 5);
    wait_strobe(3000, n);
    chk("strobe4_cycles", n, 2499);
    chk("beat4", beat, 4);
    chk("note_latency_b4", note_out, 5);
    cyc(1);
    chk("note_b4", note_out, 0);

    // Remaining strobes up to the 7 -> 0 wrap
    wait_strobe(3000, n); chk("strobe5_cycles", n, 2499); chk("beat5", beat, 5);
    wait_strobe(3000, n); chk("strobe6_cycles", n, 2500); chk("beat6", beat, 6);
    wait_strobe(3000, n); chk("strobe7_cycles", n, 2500); chk("beat7", beat, 7);
    wait_strobe(3000, n); chk("strobe8_cycles", n, 2500); chk("beat_wrap", beat, 0);

    // Pause at tick_cnt=1000 of beat 2
    wait_strobe(3000, n); chk("beat1_again", beat, 1);
    wait_strobe(3000, n); chk("beat2_again", beat, 2);
    cyc(1000);                              // tick_cnt now 1000
    play_pause = 1'b1; cyc(1); play_pause = 1'b0;
    chk("paused", running, 0);
    quiet = 1'b1;
    repeat (5000) begin
      @(negedge clk);
      if (beat_strobe !== 1'b0 || beat !== 4'd2) quiet = 1'b0;
    end
    chk("pause_hold", quiet, 1);

    // Resume: first counting edge takes tick to 1001, then 1499 edges to the wrap
    play_pause = 1'b1; cyc(1); play_pause = 1'b0;
    chk("resumed", running, 1);
    cyc(1);
    wait_strobe(3000, n);
    chk("resume_cycles", n, 1499);
    chk("resume_beat", beat, 3);

    // Tempo: 9 ups saturate at 500
    repeat (9) begin
      tempo_up = 1'b1; cyc(1); tempo_up = 1'b0; cyc(1);
    end
    wait_strobe(6000, n); chk("sync_fast", (n > 0), 1);
    wait_strobe(6000, n); chk("period_min", n, 500);

    // 20 downs saturate at 5000
    repeat (20) begin
      tempo_down = 1'b1; cyc(1); tempo_down = 1'b0; cyc(1);
    end
    wait_strobe(6000, n); chk("sync_slow", (n > 0), 1);
    wait_strobe(6000, n); chk("period_max", n, 5000);

    // Both together: no change
    tempo_up = 1'b1; tempo_down = 1'b1; cyc(1); tempo_up = 1'b0; tempo_down = 1'b0;
    wait_strobe(6000, n); chk("sync_both", (n > 0), 1);
    wait_strobe(6000, n); chk("period_both", n, 5000);

    // Cursor wrap and toggle routing
    cur_prev = 1'b1; cyc(1); cur_prev = 1'b0;
    chk("cursor_prev_wrap", cursor, 7);
    toggle_in = 1'b1; cyc(1); toggle_in = 1'b0;
    chk("toggle_step7", step_toggle, 8'h80);
    cyc(1);
    chk("toggle_width", step_toggle, 0);
    repeat (3) begin
      cur_next = 1'b1; cyc(1); cur_next = 1'b0;
    end
    chk("cursor_next_wrap", cursor, 2);
    toggle_in = 1'b1; cur_next = 1'b1; cyc(1); toggle_in = 1'b0; cur_next = 1'b0;
    chk("toggle_premove", step_toggle, 8'h04);
    chk("cursor_after_move", cursor, 3);
    cur_next = 1'b1; cur_prev = 1'b1; cyc(1); cur_next = 1'b0; cur_prev = 1'b0;
    chk("cursor_both", cursor, 3);

    // Mode drop mid-RUNNING
    step_notes = 32'h9999_9999;
    cyc(1);
    chk("note_all9", note_out, 9);
    seq_on = 1'b0; cyc(1);
    chk("drop_running", running, 0);
    chk("drop_beat", beat, 0);
    chk("drop_note", note_out, 0);
    chk("drop_strobe", beat_strobe, 0);
    toggle_in = 1'b1; cur_next = 1'b1; cyc(1); toggle_in = 1'b0; cur_next = 1'b0;
    chk("idle_toggle", step_toggle, 0);
    chk("idle_cursor_next", cursor, 3);
    cur_prev = 1'b1; cyc(1); cur_prev = 1'b0;
    chk("idle_cursor_prev", cursor, 3);
    seq_on = 1'b1; cyc(1);
    chk("return_cursor", cursor, 3);
    chk("return_running", running, 0);
    chk("return_beat", beat, 0);
    step_notes = 32'h0000_000A;
    cyc(1);
    chk("stopped_note", note_out, 10);

    // Reset mid-RUNNING restores period and cursor
    play_pause = 1'b1; cyc(1); play_pause = 1'b0;
    chk("run_before_rst", running, 1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("midrst_running", running, 0);
    chk("midrst_cursor", cursor, 0);
    chk("midrst_beat", beat, 0);
    chk("midrst_note", note_out, 0);
    cyc(1);
    play_pause = 1'b1; cyc(1); play_pause = 1'b0;
    wait_strobe(6000, n);
    chk("midrst_period", n, 2500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
